// File: rtl/cordic_arbiter.sv
// Round-robin arbiter that time-shares one iterative CORDIC engine among NUM_REQ requesters,
// with a watchdog that abandons an engine operation that never signals completion.
module cordic_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 32,
    parameter int NUM_STAGES = 13,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_angle,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       eng_start,
    output logic [WIDTH-1:0]           eng_angle,
    input  logic                       eng_done,
    input  logic [WIDTH-1:0]           eng_cos,
    input  logic [WIDTH-1:0]           eng_sin,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [WIDTH-1:0]           rsp_cos,
    output logic [WIDTH-1:0]           rsp_sin,
    output logic                       timeout_err
);
    localparam int TMO   = NUM_STAGES + 4;
    localparam int CNT_W = $clog2(TMO + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t            state_reg;
    logic [ID_W-1:0]   last_grant_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [WIDTH-1:0]  angle_reg;
    logic [ID_W-1:0]   grant_id_reg;
    logic [ID_W-1:0]   rsp_id_reg;
    logic [WIDTH-1:0]  cos_reg;
    logic [WIDTH-1:0]  sin_reg;

    logic [ID_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;
    logic [WIDTH-1:0]  angle_arr [NUM_REQ];
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_fire;

    // Candidate gi is the requester gi+1 positions after the last grant, wrapped.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [ID_W:0] sum;
            assign sum           = {1'b0, last_grant_reg} + (ID_W+1)'(gi + 1);
            assign cand_idx[gi]  = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ))
                                                                : sum[ID_W-1:0];
            assign cand_hit[gi]  = req_valid[cand_idx[gi]];
            assign angle_arr[gi] = req_angle[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Walk candidates from farthest to nearest so the nearest hit wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[i];
            end
        end
    end

    assign grant_fire = rst_n && (state_reg == IDLE) && grant_found;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_fire && (grant_idx == ID_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= ID_W'(NUM_REQ - 1);
            cnt_reg        <= '0;
            angle_reg      <= '0;
            grant_id_reg   <= '0;
            rsp_id_reg     <= '0;
            cos_reg        <= '0;
            sin_reg        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        angle_reg      <= angle_arr[grant_idx];
                        grant_id_reg   <= grant_idx;
                        last_grant_reg <= grant_idx;
                        state_reg      <= START;
                    end
                end
                START: begin
                    // Counter tracks cycles elapsed since eng_start, so it reads 1 in the first WAIT cycle.
                    cnt_reg   <= CNT_W'(1);
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (eng_done) begin
                        cos_reg    <= eng_cos;
                        sin_reg    <= eng_sin;
                        rsp_id_reg <= grant_id_reg;
                        state_reg  <= RESP;
                    end else if (cnt_reg == CNT_W'(TMO)) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Timeout is decided in the same cycle as a possible eng_done, so completion can win the tie.
    assign timeout_err = (state_reg == WAIT) && !eng_done && (cnt_reg == CNT_W'(TMO));
    assign eng_start   = (state_reg == START);
    assign eng_angle   = angle_reg;
    assign rsp_valid   = (state_reg == RESP);
    assign rsp_id      = rsp_id_reg;
    assign rsp_cos     = cos_reg;
    assign rsp_sin     = sin_reg;

endmodule

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one iterative CORDIC engine.
REQ-002 Parameter WIDTH, default 32: angle and result word width.
REQ-003 Parameter NUM_STAGES, default 13: engine iteration count; watchdog limit TMO = NUM_STAGES+4 cycles.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 req_valid  in  NUM_REQ  per-requester request.
REQ-008 req_angle  in  NUM_REQ*WIDTH  requester i angle at bits [i*WIDTH +: WIDTH].
REQ-009 req_ready  out  NUM_REQ  one-hot grant/accept strobe.
REQ-010 eng_start  out  1  one-cycle engine start pulse.
REQ-011 eng_angle  out  WIDTH  latched angle to engine.
REQ-012 eng_done  in  1  engine result-valid pulse.
REQ-013 eng_cos, eng_sin  in  WIDTH each  engine results, valid with eng_done.
REQ-014 rsp_valid  out  1  response available.
REQ-015 rsp_ready  in  1  consumer accepts response.
REQ-016 rsp_id  out  clog2(NUM_REQ)  requester index of the response.
REQ-017 rsp_cos, rsp_sin  out  WIDTH each  latched results.
REQ-018 timeout_err  out  1  one-cycle pulse on watchdog expiry.

Function
REQ-019 FSM states IDLE, START, WAIT, RESP; exactly one engine operation in flight.
REQ-020 IDLE: if any req_valid, grant index g = first asserted bit searching from last_grant+1 upward, wrapping at NUM_REQ.
REQ-021 Grant cycle: req_ready[g]=1 combinationally, all other bits 0; angle and g latched; last_grant<=g; next state START.
REQ-022 req_ready is 0 in every state except IDLE; never more than one bit set.
REQ-023 Requester dropping req_valid before grant: no state change, no grant.
REQ-024 START: eng_start=1 for exactly one cycle; eng_angle holds the latched angle from START until the next grant; watchdog counter cleared; next state WAIT.
REQ-025 WAIT: counter increments each cycle; on eng_done latch eng_cos/eng_sin, next state RESP.
REQ-026 WAIT: if counter reaches TMO with no eng_done, timeout_err=1 one cycle, no response issued, next state IDLE.
REQ-027 eng_done and timeout in the same cycle: eng_done wins, no timeout_err.
REQ-028 eng_done in IDLE, START or RESP: ignored, results not latched.
REQ-029 RESP: rsp_valid=1, rsp_id/rsp_cos/rsp_sin stable until rsp_ready sampled high; then next state IDLE.
REQ-030 Latency: grant at cycle T, eng_start at T+1, eng_done at T+1+k (1<=k<TMO+1), rsp_valid at T+2+k.
REQ-031 Back-to-back: new grant earliest cycle after rsp_valid&rsp_ready.
REQ-032 Fairness: with all requesters continuously valid, grants cycle 0,1,2,3,0...; no requester waits more than NUM_REQ-1 other grants.

Reset
REQ-033 rst_n low at clock edge: state IDLE, last_grant=NUM_REQ-1 (requester 0 first priority), counter 0.
REQ-034 Outputs in reset: req_ready=0, eng_start=0, eng_angle=0, rsp_valid=0, rsp_id=0, rsp_cos=0, rsp_sin=0, timeout_err=0.
REQ-035 Reset mid-operation (START/WAIT/RESP) abandons the operation; a later eng_done is ignored and no response issued.

Verification
REQ-036 Single request: req_valid=4'b0100, angle 0x2000_0000, eng_done at 13 cycles after eng_start -> req_ready=4'b0100, eng_angle=0x2000_0000, rsp_valid with rsp_id=2 one cycle after eng_done.
REQ-037 All four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0 after reset.
REQ-038 eng_done withheld -> timeout_err pulse exactly 17 cycles after eng_start (NUM_STAGES=13), no rsp_valid, FSM back in IDLE.
REQ-039 rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_id/rsp_cos/rsp_sin stable, req_ready=0 throughout.
REQ-040 rst_n low during WAIT, eng_done arrives after release -> no rsp_valid, all outputs at reset values, next grant goes to requester 0.
REQ-041 Spurious eng_done in IDLE with req_valid=0 -> no output change.
